fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  in  1  synchronous, active-high reset.
REQ-003 start_i  in  1  fetch enable; fetching begins on first cycle high.
REQ-004 stall_i  in  1  load-use stall from hazard detection; hold PC and IF/ID.
REQ-005 flush_i  in  1  taken branch resolved in ID; squash IF/ID, redirect PC.
REQ-006 branch_addr_i  in  32  redirect target, sampled only when flush_i=1.
REQ-007 imem_req_o  out  1  instruction-memory request.
REQ-008 imem_addr_o  out  32  request address (current PC).
REQ-009 imem_ready_i  in  1  imem_data_i valid this cycle; completes request.
REQ-010 imem_data_i  in  32  fetched instruction word.
REQ-011 pc_o  out  32  IF/ID PC of held instruction.
REQ-012 instr_o  out  32  IF/ID instruction; 32'h0 (NOP) when invalid.
REQ-013 valid_o  out  1  IF/ID holds a real instruction.
REQ-014 busy_o  out  1  request outstanding (REQ state, imem_ready_i low).

Function
REQ-015 States SHALL be IDLE, REQ, HOLD; encoding free.
REQ-016 IDLE: imem_req_o=0; start_i=1 -> REQ next cycle.
REQ-017 REQ: imem_req_o=1, imem_addr_o=PC; address SHALL stay stable until imem_ready_i=1.
REQ-018 REQ, ready=1, no flush, no redirect pending, stall_i=0: IF/ID<={PC,data}, valid_o<=1, PC<=PC+4, stay REQ.
REQ-019 REQ, ready=1, stall_i=1, no flush: data and PC captured in a one-entry hold buffer, IF/ID unchanged, -> HOLD.
REQ-020 HOLD: imem_req_o=0; when stall_i=0 load buffer into IF/ID, valid_o<=1, PC<=PC+4, -> REQ.
REQ-021 Flush priority SHALL exceed stall: flush_i=1 in any non-IDLE state -> valid_o<=0, instr_o<=0 next cycle regardless of stall_i.
REQ-022 Flush in HOLD, or in REQ with ready=1: buffer/returned data discarded, PC<=branch_addr_i, -> REQ.
REQ-023 Flush in REQ with ready=0: branch_addr_i latched into redirect register, redirect_pending set; request continues unchanged.
REQ-024 REQ, ready=1, redirect_pending=1: data discarded, PC<=redirect target, pending cleared, IF/ID stays invalid; a flush that same cycle overrides with branch_addr_i.
REQ-025 Second flush while redirect pending SHALL overwrite the redirect target.
REQ-026 REQ, no ready, stall_i=0, no flush: valid_o<=0 (bubble); stall_i=1: IF/ID holds.
REQ-027 PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
REQ-028 start_i low in REQ: outstanding request completes per REQ-018..024, then -> IDLE; in HOLD: buffer delivered first, then IDLE.
REQ-029 Stall deasserted in same cycle ready arrives SHALL follow REQ-018 (no HOLD).
REQ-030 busy_o SHALL be combinational from state and imem_ready_i.

Reset
REQ-031 rst_i=1 at clock edge: state<=IDLE, PC<=0, pc_o<=0, instr_o<=0, valid_o<=0, redirect_pending<=0, hold buffer invalid.
REQ-032 Reset SHALL override all inputs, including mid-request; any subsequent imem_ready_i before next REQ is ignored.
REQ-033 Outputs during reset cycle: imem_req_o=0, busy_o=0.

Verification
REQ-034 Reset, start_i=1, imem ready every cycle, data=PC^32'hA5A5A5A5 -> pc_o 0,4,8,... one per cycle, valid_o=1 from cycle 2.
REQ-035 stall_i=1 for 2 cycles while ready arrives at PC=8 -> IF/ID holds PC 4 instr, HOLD entered, then pc_o=8 on release, no duplicate or drop.
REQ-036 flush_i=1, branch_addr_i=32'h100 with stall_i=1 -> valid_o=0 next cycle, next imem_addr_o=32'h100.
REQ-037 imem ready delayed 3 cycles, flush to 32'h200 on first wait cycle -> addr stable, returned word discarded, next addr 32'h200, valid_o=0 throughout.
REQ-038 PC=32'hFFFFFFFC fetched -> next imem_addr_o=0.
REQ-039 rst_i asserted while REQ waiting, ready arrives 1 cycle later -> outputs at reset values, IF/ID stays invalid.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: pipeline control inputs, instruction-memory handshake and IF/ID outputs.
interface fetch_unit_if;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        busy_o;

  modport slave (
    input  start_i, stall_i, flush_i, branch_addr_i, imem_ready_i, imem_data_i,
    output imem_req_o, imem_addr_o, pc_o, instr_o, valid_o, busy_o
  );

  modport master (
    output start_i, stall_i, flush_i, branch_addr_i, imem_ready_i, imem_data_i,
    input  imem_req_o, imem_addr_o, pc_o, instr_o, valid_o, busy_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem requests from the PC and fills the IF/ID register.
// state | meaning
// IDLE  | not fetching, no request issued
// REQ   | request for PC outstanding until imem_ready_i
// HOLD  | returned word parked in hold buffer while the pipeline is stalled
module fetch_unit (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.slave  fu
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        valid_q, valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  state_t      run_next;

  // Once a request completes, dropping start_i parks the unit in IDLE.
  assign run_next = fu.start_i ? REQ : IDLE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    valid_d      = valid_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    case (state_q)
      IDLE: begin
        if (fu.start_i) state_d = REQ;
      end

      REQ: begin
        if (!fu.imem_ready_i) begin
          if (fu.flush_i) begin
            redir_pend_d = 1'b1;
            redir_addr_d = fu.branch_addr_i;
            valid_d      = 1'b0;
            ifid_instr_d = 32'h0;
          end else if (!fu.stall_i) begin
            valid_d      = 1'b0;
            ifid_instr_d = 32'h0;
          end
        end else if (fu.flush_i) begin
          valid_d      = 1'b0;
          ifid_instr_d = 32'h0;
          pc_d         = fu.branch_addr_i;
          redir_pend_d = 1'b0;
          state_d      = run_next;
        end else if (redir_pend_q) begin
          // Word belongs to the squashed path; only the redirect survives.
          valid_d      = 1'b0;
          ifid_instr_d = 32'h0;
          pc_d         = redir_addr_q;
          redir_pend_d = 1'b0;
          state_d      = run_next;
        end else if (fu.stall_i) begin
          hold_pc_d    = pc_q;
          hold_instr_d = fu.imem_data_i;
          state_d      = HOLD;
        end else begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = fu.imem_data_i;
          valid_d      = 1'b1;
          pc_d         = pc_q + 32'd4;
          state_d      = run_next;
        end
      end

      HOLD: begin
        if (fu.flush_i) begin
          valid_d      = 1'b0;
          ifid_instr_d = 32'h0;
          pc_d         = fu.branch_addr_i;
          state_d      = run_next;
        end else if (!fu.stall_i) begin
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          valid_d      = 1'b1;
          pc_d         = hold_pc_q + 32'd4;
          state_d      = run_next;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_addr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      valid_q      <= valid_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Reset gating keeps the request lines quiet during the reset cycle itself.
  assign fu.imem_req_o  = (state_q == REQ) && !rst_i;
  assign fu.busy_o      = (state_q == REQ) && !fu.imem_ready_i && !rst_i;
  assign fu.imem_addr_o = pc_q;
  assign fu.pc_o        = ifid_pc_q;
  assign fu.instr_o     = ifid_instr_q;
  assign fu.valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed scenarios then random traffic, all checked against a fetch model.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  fetch_unit_if fu ();

  fetch_unit dut (.clk_i(clk_i), .rst_i(rst_i), .fu(fu.slave));

  always #5 clk_i = ~clk_i;

  // Memory returns a word derived from the address being requested.
  assign fu.imem_data_i = fu.imem_addr_o ^ KEY;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch stage is doing, not how the RTL encodes it.
  bit          m_fetching, m_parked, m_redir, m_valid;
  logic [31:0] m_pc, m_out_pc, m_out_instr, m_redir_addr, m_park_pc, m_park_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetching = 0; m_parked = 0; m_redir = 0; m_valid = 0;
    m_pc = 0; m_out_pc = 0; m_out_instr = 0; m_redir_addr = 0;
    m_park_pc = 0; m_park_instr = 0;
  endtask

  task automatic squash();
    m_valid = 0;
    m_out_instr = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit st, input bit fl,
                            input logic [31:0] ba, input bit rdy);
    if (r) begin
      model_reset();
    end else if (m_parked) begin
      if (fl) begin
        squash(); m_pc = ba; m_parked = 0; m_fetching = s;
      end else if (!st) begin
        m_out_pc = m_park_pc; m_out_instr = m_park_instr; m_valid = 1;
        m_pc = m_park_pc + 4; m_parked = 0; m_fetching = s;
      end
    end else if (m_fetching) begin
      if (!rdy) begin
        if (fl) begin
          m_redir = 1; m_redir_addr = ba; squash();
        end else if (!st) squash();
      end else if (fl) begin
        squash(); m_pc = ba; m_redir = 0; m_fetching = s;
      end else if (m_redir) begin
        squash(); m_pc = m_redir_addr; m_redir = 0; m_fetching = s;
      end else if (st) begin
        m_parked = 1; m_park_pc = m_pc; m_park_instr = m_pc ^ KEY; m_fetching = 0;
      end else begin
        m_out_pc = m_pc; m_out_instr = m_pc ^ KEY; m_valid = 1;
        m_pc = m_pc + 4; m_fetching = s;
      end
    end else if (s) begin
      m_fetching = 1;
    end
  endtask

  // One clock: drive at the falling edge, compare just after, advance the model to the next edge.
  task automatic cycle(input bit r, input bit s, input bit st, input bit fl,
                       input logic [31:0] ba, input bit rdy);
    @(negedge clk_i);
    rst_i = r; fu.start_i = s; fu.stall_i = st; fu.flush_i = fl;
    fu.branch_addr_i = ba; fu.imem_ready_i = rdy;
    #1;
    chk("req",   fu.imem_req_o, !r && m_fetching);
    chk("busy",  fu.busy_o,     !r && m_fetching && !rdy);
    if (m_fetching) chk("addr", fu.imem_addr_o, m_pc);
    chk("pc_o",  fu.pc_o,    m_out_pc);
    chk("instr", fu.instr_o, m_out_instr);
    chk("valid", fu.valid_o, m_valid);
    model_step(r, s, st, fl, ba, rdy);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    fu.start_i = 0; fu.stall_i = 0; fu.flush_i = 0;
    fu.branch_addr_i = 0; fu.imem_ready_i = 0;
    repeat (2) @(posedge clk_i);
    model_reset();

    do_reset();
    chk("rst_pc_o",  fu.pc_o, 32'h0);
    chk("rst_valid", fu.valid_o, 32'h0);

    // Back-to-back fetch, memory ready every cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 0, 1);
      if (i == 1) chk("seq_valid_early", fu.valid_o, 32'h0);
      if (i >= 2) begin
        chk("seq_pc", fu.pc_o, 32'((i - 2) * 4));
        chk("seq_valid", fu.valid_o, 32'h1);
      end
    end

    // Stall arrives together with the word for PC 8.
    do_reset();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 0);
    chk("hold_pc", fu.pc_o, 32'h4);
    chk("hold_req", fu.imem_req_o, 32'h0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("hold_pc2", fu.pc_o, 32'h4);
    cycle(0, 1, 0, 0, 0, 0);
    chk("release_pc", fu.pc_o, 32'h8);
    chk("release_valid", fu.valid_o, 32'h1);
    chk("release_addr", fu.imem_addr_o, 32'hC);

    // Flush beats stall.
    cycle(0, 1, 1, 1, 32'h100, 1);
    cycle(0, 1, 0, 0, 0, 0);
    chk("flush_valid", fu.valid_o, 32'h0);
    chk("flush_addr", fu.imem_addr_o, 32'h100);

    // Flush while the memory is slow: address held, returned word dropped.
    cycle(0, 1, 0, 1, 32'h200, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("slow_addr", fu.imem_addr_o, 32'h100);
    cycle(0, 1, 0, 0, 0, 0);
    chk("slow_valid", fu.valid_o, 32'h0);
    cycle(0, 1, 0, 0, 0, 1);
    chk("slow_addr2", fu.imem_addr_o, 32'h100);
    cycle(0, 1, 0, 0, 0, 0);
    chk("redir_addr", fu.imem_addr_o, 32'h200);
    chk("redir_valid", fu.valid_o, 32'h0);

    // PC wrap at the top of the address space.
    cycle(0, 1, 0, 1, 32'hFFFFFFFC, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);
    chk("wrap_addr", fu.imem_addr_o, 32'h0);
    chk("wrap_pc", fu.pc_o, 32'hFFFFFFFC);

    // Reset in the middle of a wait; the late ready must be ignored.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("rst_mid_valid", fu.valid_o, 32'h0);
    chk("rst_mid_req", fu.imem_req_o, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_mid_pc", fu.pc_o, 32'h0);
    chk("rst_mid_instr", fu.instr_o, 32'h0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, s, st, fl, rdy;
      logic [31:0] ba;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      ba  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC);
      cycle(r, s, st, fl, ba, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
